// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline hazard path
// Purpose: memory-wait FSM state encoding, the hardwired-zero register number
//          and the default statistics counter width.
// Ports:   none (package).
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } state_e;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         CNT_W_DEF = 16;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational read-after-write hazard detector
// Purpose: flags an ID-stage instruction whose sources collide with a pending
//          write in EXE or MEM that the pipeline cannot satisfy this cycle.
// Ports:   src1/src2/two_src      ID source registers, src2 valid flag
//          exe_dest/exe_wb_en/exe_mem_r_en  EXE destination, write-back, load
//          mem_dest/mem_wb_en     MEM destination, write-back
//          hazard                 ID must stall one cycle
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  input  logic       two_src,
  input  logic [4:0] exe_dest,
  input  logic       exe_wb_en,
  input  logic       exe_mem_r_en,
  input  logic [4:0] mem_dest,
  input  logic       mem_wb_en,
  output logic       hazard
);

  logic src1_live, src2_live;
  logic on_exe, on_mem;
  logic hz_fwd, hz_nofwd;

  always_comb begin
    // Register 0 is hardwired, so it can never be the subject of a hazard.
    src1_live = (src1 != REG_ZERO);
    src2_live = two_src && (src2 != REG_ZERO);
    on_exe    = (src1_live && (src1 == exe_dest)) || (src2_live && (src2 == exe_dest));
    on_mem    = (src1_live && (src1 == mem_dest)) || (src2_live && (src2 == mem_dest));
    // With forwarding only a load in EXE is too late to bypass.
    hz_fwd    = on_exe && exe_mem_r_en;
    hz_nofwd  = (on_exe && exe_wb_en) || (on_mem && mem_wb_en);
    hazard    = (FWD_EN != 0) ? hz_fwd : hz_nofwd;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
// Purpose: arbitrates memory stalls, taken branches and data hazards into
//          freeze/flush controls, tracks the memory-wait FSM with timeout,
//          and counts stall and flush cycles.
// Ports:   clk, rst (async active-low)
//          src1/src2/two_src/exe_*/mem_dest/mem_wb_en  hazard inputs
//          mem_op/mem_ready  data memory handshake; br_taken  EXE branch
//          freeze_*/flush_*/wb_bubble  stage register controls (combinational)
//          mem_err  sticky timeout; stall_cnt/flush_cnt  saturating counters
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             two_src,
  input  logic [4:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_op,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             freeze_id_exe,
  output logic             freeze_exe_mem,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [15:0]      TIMEOUT_W = 16'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic mstall, br_act, hz_stall;

  hazard_detect #(.FWD_EN(FWD_EN)) u_hazard_detect (
    .src1         (src1),
    .src2         (src2),
    .two_src      (two_src),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hazard       (hazard)
  );

  // Priority mux: a memory stall holds EXE, so a branch or hazard seen during
  // it re-presents once the stall releases and is ignored here.
  always_comb begin
    mstall   = (state_q == RUN) ? (mem_op && !mem_ready) : !mem_ready;
    br_act   = br_taken && !mstall;
    hz_stall = hazard && !mstall && !br_taken;

    freeze_pc      = rst && (mstall || hz_stall);
    freeze_if_id   = rst && (mstall || hz_stall);
    freeze_id_exe  = rst && mstall;
    freeze_exe_mem = rst && mstall;
    wb_bubble      = rst && mstall;
    flush_if_id    = rst && br_act;
    flush_id_exe   = rst && (br_act || hz_stall);
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = mem_err_q;
    case (state_q)
      RUN: begin
        if (mem_op && !mem_ready) begin
          state_d = MEM_WAIT;
          wcnt_d  = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
          wcnt_d  = 16'd0;
        end else if (wcnt_q == TIMEOUT_W) begin
          // Give up on the access; this cycle still froze, the next is free.
          state_d   = RUN;
          wcnt_d    = 16'd0;
          mem_err_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = 16'd0;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if ((mstall || hz_stall) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    flush_cnt_d = flush_cnt_q;
    if (br_act && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wcnt_q      <= 16'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It decides each cycle whether the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers load, hold or bubble, based on three conditions:
- register read-after-write hazards,
- taken branches resolved in EXE,
- multi-cycle data-memory accesses.

It owns the only sequential policy state in the hazard path: the memory-wait FSM, its timeout and the stall/flush statistics counters.

## Interface
- FWD_EN, 1: forwarding unit present; when 1, only load-use hazards stall.
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before error; legal range 1..65535.
- CNT_W, 16: width of statistics counters.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- src1, src2  in  5  ID-stage source register numbers.
- two_src  in  1  ID instruction reads src2 as a register.
- exe_dest  in  5  destination register in ID/EXE output.
- exe_wb_en, exe_mem_r_en  in  1  EXE-stage write-back enable and load flag.
- mem_dest  in  5  destination register in EXE/MEM output.
- mem_wb_en  in  1  MEM-stage write-back enable.
- mem_op  in  1  MEM stage holds a load or store (MEM_R_EN | MEM_W_EN).
- mem_ready  in  1  data memory completes the access this cycle.
- br_taken  in  1  EXE resolved a taken branch.
- freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem  out  1  hold the register.
- flush_if_id, flush_id_exe  out  1  load a bubble (all enables 0) next edge.
- wb_bubble  out  1  MEM/WB loads a bubble (memory stall).
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- States: RUN, MEM_WAIT (2-bit encoding, RUN=0). A wait counter `wcnt` (16 bit) exists only in MEM_WAIT.
- Register 0 never hazards: src==0 is ignored.
- Data hazard, FWD_EN=0: src matches exe_dest with exe_wb_en, or matches mem_dest with mem_wb_en. src1 is always checked; src2 is checked only when two_src=1.
- Data hazard, FWD_EN=1: src matches exe_dest with exe_mem_r_en.
- Memory stall, `mstall`:
  - In RUN: (mem_op & ~mem_ready).
  - In MEM_WAIT: ~mem_ready.
- Priority, highest first: mstall > br_taken > data hazard.
- mstall:
  - freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem = 1.
  - wb_bubble = 1.
  - All flushes 0; br_taken and hazards are ignored, since EXE is held and they re-present afterwards.
- br_taken, no mstall: flush_if_id = flush_id_exe = 1, all freezes 0.
- Data hazard only: freeze_pc = freeze_if_id = 1, flush_id_exe = 1, others 0.
- No condition: all outputs 0.
- FSM transitions:
  - RUN -> MEM_WAIT when mem_op & ~mem_ready; wcnt <= 1.
  - MEM_WAIT -> RUN when mem_ready.
  - MEM_WAIT -> RUN with mem_err <= 1 when wcnt == MEM_TIMEOUT and ~mem_ready. That cycle still freezes; the next cycle is released.
  - Otherwise wcnt increments.
- mem_ready in the same cycle as mem_op in RUN: no stall, no state change.
- Counters: stall_cnt +1 on every cycle with mstall or data-hazard stall. flush_cnt +1 on every cycle with flush_if_id. Both saturate at all-ones.
- mem_err clears only on reset.

## Timing
- All freeze/flush outputs are combinational from inputs and the current state; there is no added latency. Pipeline registers sample them on the same edge.
- State, wcnt, mem_err and counters update on the rising clk edge.
- Reset: rst low asynchronously forces state=RUN, wcnt=0, mem_err=0, stall_cnt=0, flush_cnt=0. All freeze, flush and wb_bubble outputs are forced 0 while rst=0.
- Reset mid-MEM_WAIT returns to RUN immediately; there is no pending-access memory.
- Load-use with FWD_EN=1 costs exactly 1 bubble. With FWD_EN=0, a hazard on EXE costs 2 bubbles and a hazard on MEM costs 1.
- A memory access with first-cycle latency N produces N-1... (see test 4): N ready-low cycles produce N frozen cycles.

## Structure
- Shared package `pipeline_pkg` holds:
  - state enum (RUN, MEM_WAIT),
  - REG_ZERO = 5'd0,
  - the CNT_W default.
- One natural sub-module, `hazard_detect`: purely combinational. It takes the src/dest/enable inputs and FWD_EN and outputs `hazard`.
- The FSM, priority mux and counters live in the top.

## Test plan
- Hazard with FWD_EN=0: src1=3, exe_dest=3, exe_wb_en=1 -> freeze_pc=freeze_if_id=flush_id_exe=1. src1=0 with exe_dest=0 -> no stall.
- Load-use with FWD_EN=1: src2=5, two_src=1, exe_dest=5, exe_mem_r_en=1 -> one-cycle stall, stall_cnt=1. Same case with two_src=0 -> no stall.
- Branch: br_taken=1 together with a data hazard -> flush_if_id=flush_id_exe=1, freeze_pc=0, flush_cnt=1.
- Memory wait: mem_op=1 with mem_ready low for 3 cycles, then high -> 3 cycles of all-freeze plus wb_bubble; state returns to RUN; br_taken asserted during the wait is ignored.
- Timeout with MEM_TIMEOUT=4: mem_ready held low -> mem_err=1 after the 5th frozen cycle; then RUN; mem_err stays 1.
- Async reset: drop rst mid-MEM_WAIT between edges -> outputs 0 and state RUN immediately; counters 0.
